spi_slave: RTL



---
 rtl/spi_pkg.sv | 13 +
 rtl/spi_sync_edge.sv | 30 +++
 rtl/spi_slave.sv | 138 +++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: FSM state encodings and SPI mode constants ({cpol,cpha}) shared by the responder and benches.
package spi_pkg;
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2,
      S_HOLD  = 2'd3
   } spi_state_e;
   localparam logic [1:0] MODE0 = 2'b00;
   localparam logic [1:0] MODE1 = 2'b01;
   localparam logic [1:0] MODE2 = 2'b10;
   localparam logic [1:0] MODE3 = 2'b11;
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchroniser with a delay flop for rise/fall detection on the synchronised level.
module spi_sync_edge #(
   parameter int   SYNC_STAGES = 2,
   parameter logic RST_VAL     = 1'b0
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_d,
   output logic o_q,
   output logic o_rise,
   output logic o_fall
);
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   dly_q, dly_d;
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], i_d};
      dly_d  = sync_q[SYNC_STAGES-1];
   end
   always_ff @(posedge i_clk)
      if (i_rst) begin
         sync_q <= {SYNC_STAGES{RST_VAL}};
         dly_q  <= RST_VAL;
      end else begin
         sync_q <= sync_d;
         dly_q  <= dly_d;
      end
   assign o_q    = sync_q[SYNC_STAGES-1];
   assign o_rise = o_q & ~dly_q;
   assign o_fall = ~o_q & dly_q;
endmodule

// File: rtl/spi_slave.sv
// spi_slave: oversampling SPI responder; one DATA_WIDTH frame per CS-low window, MSB first, all four modes.
module spi_slave
   import spi_pkg::*;
#(
   parameter int DATA_WIDTH  = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_cpol,
   input  logic                  i_cpha,
   input  logic                  i_spi_clk,
   input  logic                  i_cs,
   input  logic                  i_mosi,
   output logic                  o_miso,
   output logic                  o_miso_oe,
   input  logic [DATA_WIDTH-1:0] i_miso_data,
   output logic [DATA_WIDTH-1:0] o_mosi_data,
   output logic                  o_valid,
   output logic                  o_abort,
   output logic                  o_overrun,
   output logic [31:0]           mosi_m_axis_tdata,
   output logic                  mosi_m_axis_tvalid,
   output logic [1:0]            o_spi_state
);
   localparam int CW = $clog2(DATA_WIDTH) + 1;
   spi_state_e            state_q, state_d;
   logic [DATA_WIDTH-1:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, mosi_data_q, mosi_data_d;
   logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
   logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
   logic cpol_q, cpol_d, cpha_q, cpha_d, first_q, first_d;
   logic overrun_q, overrun_d, valid_q, valid_d, abort_q, abort_d;
   logic sclk_s, sclk_rise, sclk_fall, cs_s, cs_rise, cs_fall;
   logic mosi_s, sclk_edge, lead, trail, sample, shift;

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
      .i_clk(i_clk), .i_rst(i_rst), .i_d(i_spi_clk), .o_q(sclk_s), .o_rise(sclk_rise), .o_fall(sclk_fall)
   );
   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
      .i_clk(i_clk), .i_rst(i_rst), .i_d(i_cs), .o_q(cs_s), .o_rise(cs_rise), .o_fall(cs_fall)
   );

   // A lead edge leaves the idle level, so the new level differs from cpol.
   always_comb begin
      mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], i_mosi};
      mosi_s      = mosi_sync_q[SYNC_STAGES-1];
      sclk_edge   = sclk_rise | sclk_fall;
      lead        = sclk_edge & (sclk_s != cpol_q);
      trail       = sclk_edge & (sclk_s == cpol_q);
      sample      = cpha_q ? trail : lead;
      shift       = cpha_q ? (lead & ~first_q) : trail;
   end

   always_comb begin
      tx_sh_d     = tx_sh_q;
      rx_sh_d     = rx_sh_q;
      bit_cnt_d   = bit_cnt_q;
      cpol_d      = cpol_q;
      cpha_d      = cpha_q;
      first_d     = first_q;
      overrun_d   = overrun_q;
      mosi_data_d = mosi_data_q;
      if (state_q == S_IDLE && cs_fall) begin
         cpol_d    = i_cpol;
         cpha_d    = i_cpha;
         tx_sh_d   = i_miso_data;
         bit_cnt_d = '0;
         overrun_d = 1'b0;
         first_d   = 1'b1;
      end
      if (state_q == S_SHIFT) begin
         if (sample) begin
            rx_sh_d   = {rx_sh_q[DATA_WIDTH-2:0], mosi_s};
            bit_cnt_d = bit_cnt_q + CW'(1);
         end
         if (shift) tx_sh_d = tx_sh_q << 1;
         if (lead) first_d = 1'b0;
      end
      if (state_q == S_DONE) mosi_data_d = rx_sh_q;
      // Only leads count as overrun: the CPHA=0 final trail is still part of the frame.
      if (state_q == S_HOLD && lead) overrun_d = 1'b1;
      valid_d = state_q == S_DONE;
      abort_d = state_q == S_SHIFT && cs_rise && bit_cnt_d != CW'(DATA_WIDTH);
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  state_d = cs_fall ? S_SHIFT : S_IDLE;
         S_SHIFT: state_d = (bit_cnt_d == CW'(DATA_WIDTH)) ? S_DONE : cs_rise ? S_IDLE : S_SHIFT;
         S_DONE:  state_d = S_HOLD;
         S_HOLD:  state_d = cs_s ? S_IDLE : S_HOLD;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk)
      if (i_rst) begin
         state_q     <= S_IDLE;
         tx_sh_q     <= '0;
         rx_sh_q     <= '0;
         bit_cnt_q   <= '0;
         cpol_q      <= 1'b0;
         cpha_q      <= 1'b0;
         first_q     <= 1'b0;
         mosi_data_q <= '0;
         overrun_q   <= 1'b0;
         valid_q     <= 1'b0;
         abort_q     <= 1'b0;
         mosi_sync_q <= '0;
      end else begin
         state_q     <= state_d;
         tx_sh_q     <= tx_sh_d;
         rx_sh_q     <= rx_sh_d;
         bit_cnt_q   <= bit_cnt_d;
         cpol_q      <= cpol_d;
         cpha_q      <= cpha_d;
         first_q     <= first_d;
         mosi_data_q <= mosi_data_d;
         overrun_q   <= overrun_d;
         valid_q     <= valid_d;
         abort_q     <= abort_d;
         mosi_sync_q <= mosi_sync_d;
      end

   always_comb begin
      o_miso_oe = state_q != S_IDLE;
      o_miso    = o_miso_oe & tx_sh_q[DATA_WIDTH-1];
   end

   assign o_mosi_data        = mosi_data_q;
   assign o_valid            = valid_q;
   assign o_abort            = abort_q;
   assign o_overrun          = overrun_q;
   assign mosi_m_axis_tdata  = 32'(mosi_data_q);
   assign mosi_m_axis_tvalid = valid_q;
   assign o_spi_state        = state_q;
endmodule
